instruction_decode_stage: RTL



---
 rtl/instruction_decode_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/instruction_decode_stage.sv
// Decode stage: decodes the fetched word, reads the register file, detects
// RAW hazards against the EX and MEM in-flight writers (no forwarding),
// resolves J/BEQ redirects and loads the ID/EX pipeline register.
module instruction_decode_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_ins,
    input  logic [15:0] i_current_address,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic [4:0]  o_rs_addr,
    output logic [4:0]  o_rt_addr,
    output logic        o_stall,
    output logic        o_stall_pm,
    output logic        o_pc_mux_sel,
    output logic [15:0] o_jmp_loc,
    output logic [31:0] o_ex_ins,
    output logic [15:0] o_ex_pc,
    output logic [31:0] o_ex_rs_data,
    output logic [31:0] o_ex_rt_data,
    output logic [31:0] o_ex_imm,
    output logic [4:0]  o_ex_dest,
    output logic        o_ex_reg_write,
    output logic        o_ex_mem_read,
    output logic        o_ex_mem_write
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [5:0]  w_op;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic        w_rd_rs, w_rd_rt, w_we, w_mr, w_mw, w_is_j, w_is_beq;
    logic [4:0]  w_dest;
    logic        w_stall, w_take;
    logic [15:0] w_br_tgt;

    logic [15:0] r_pc_q;
    logic        r_stall_pm;
    logic [31:0] r_ex_ins, r_ex_rs_data, r_ex_rt_data, r_ex_imm;
    logic [15:0] r_ex_pc;
    logic [4:0]  r_ex_dest, r_mem_dest;
    logic        r_ex_we, r_ex_mr, r_ex_mw, r_mem_we;

    assign w_op = i_ins[31:26];
    assign w_rs = i_ins[25:21];
    assign w_rt = i_ins[20:16];
    assign w_rd = i_ins[15:11];

    // Opcode decode: which sources are read and what the instruction writes
    always_comb begin
        w_rd_rs  = 1'b0;
        w_rd_rt  = 1'b0;
        w_dest   = 5'd0;
        w_we     = 1'b0;
        w_mr     = 1'b0;
        w_mw     = 1'b0;
        w_is_j   = 1'b0;
        w_is_beq = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_rd_rs = 1'b1;
                w_rd_rt = 1'b1;
                w_dest  = w_rd;
                w_we    = (w_rd != 5'd0);
            end
            OP_ADDI: begin
                w_rd_rs = 1'b1;
                w_dest  = w_rt;
                w_we    = 1'b1;
            end
            OP_LW: begin
                w_rd_rs = 1'b1;
                w_dest  = w_rt;
                w_we    = 1'b1;
                w_mr    = 1'b1;
            end
            OP_SW: begin
                w_rd_rs = 1'b1;
                w_rd_rt = 1'b1;
                w_mw    = 1'b1;
            end
            OP_BEQ: begin
                w_rd_rs  = 1'b1;
                w_rd_rt  = 1'b1;
                w_is_beq = 1'b1;
            end
            OP_J:    w_is_j = 1'b1;
            default: ;
        endcase
    end

    // A source conflicts if it is a real register pending a write in EX or MEM
    function automatic logic src_hit(input logic [4:0] a, input logic en,
                                     input logic [4:0] ex_d, input logic ex_w,
                                     input logic [4:0] mem_d, input logic mem_w);
        return en && (a != 5'd0) &&
               ((ex_w && (a == ex_d)) || (mem_w && (a == mem_d)));
    endfunction

    assign w_stall = i_reset &&
        (src_hit(w_rs, w_rd_rs, r_ex_dest, r_ex_we, r_mem_dest, r_mem_we) ||
         src_hit(w_rt, w_rd_rt, r_ex_dest, r_ex_we, r_mem_dest, r_mem_we));

    // Redirect only once the instruction is free to leave decode
    assign w_br_tgt = r_pc_q + 16'd1 + i_ins[15:0];
    assign w_take   = i_reset && !w_stall &&
                      (w_is_j || (w_is_beq && (i_rs_data == i_rt_data)));

    assign o_rs_addr    = w_rs;
    assign o_rt_addr    = w_rt;
    assign o_stall      = w_stall;
    assign o_pc_mux_sel = w_take;
    assign o_jmp_loc    = !w_take ? 16'd0 : (w_is_j ? i_ins[15:0] : w_br_tgt);

    // PC tracking, stall replay flag, MEM tracker and ID/EX register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc_q       <= '0;
            r_stall_pm   <= 1'b0;
            r_ex_ins     <= '0;
            r_ex_pc      <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_imm     <= '0;
            r_ex_dest    <= '0;
            r_ex_we      <= 1'b0;
            r_ex_mr      <= 1'b0;
            r_ex_mw      <= 1'b0;
            r_mem_dest   <= '0;
            r_mem_we     <= 1'b0;
        end else begin
            r_stall_pm <= w_stall;
            r_mem_dest <= r_ex_dest;
            r_mem_we   <= r_ex_we;
            if (!w_stall) r_pc_q <= i_current_address;
            if (w_stall) begin
                r_ex_ins     <= '0;
                r_ex_pc      <= '0;
                r_ex_rs_data <= '0;
                r_ex_rt_data <= '0;
                r_ex_imm     <= '0;
                r_ex_dest    <= '0;
                r_ex_we      <= 1'b0;
                r_ex_mr      <= 1'b0;
                r_ex_mw      <= 1'b0;
            end else begin
                r_ex_ins     <= i_ins;
                r_ex_pc      <= r_pc_q;
                r_ex_rs_data <= i_rs_data;
                r_ex_rt_data <= i_rt_data;
                r_ex_imm     <= {{16{i_ins[15]}}, i_ins[15:0]};
                r_ex_dest    <= w_dest;
                r_ex_we      <= w_we;
                r_ex_mr      <= w_mr;
                r_ex_mw      <= w_mw;
            end
        end
    end

    assign o_stall_pm     = r_stall_pm;
    assign o_ex_ins       = r_ex_ins;
    assign o_ex_pc        = r_ex_pc;
    assign o_ex_rs_data   = r_ex_rs_data;
    assign o_ex_rt_data   = r_ex_rt_data;
    assign o_ex_imm       = r_ex_imm;
    assign o_ex_dest      = r_ex_dest;
    assign o_ex_reg_write = r_ex_we;
    assign o_ex_mem_read  = r_ex_mr;
    assign o_ex_mem_write = r_ex_mw;
endmodule
